// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit bridging the memory stage to a variable-latency bus.
// Handles lane alignment, load extension, misaligned/illegal/timeout reporting.
module riscv_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_lsu_valid,
    output logic                o_lsu_ready,
    input  logic                i_lsu_we,
    input  logic [2:0]          i_lsu_funct3,
    input  logic [XLEN-1:0]     i_lsu_addr,
    input  logic [XLEN-1:0]     i_lsu_wr_data,
    output logic                o_lsu_done,
    output logic [XLEN-1:0]     o_lsu_rd_data,
    output logic                o_lsu_err,
    output logic [1:0]          o_lsu_err_code,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [XLEN-1:0]     o_bus_addr,
    output logic [XLEN/8-1:0]   o_bus_byte_sel,
    output logic [XLEN-1:0]     o_bus_wr_data,
    input  logic                i_bus_ack,
    input  logic [XLEN-1:0]     i_bus_rd_data
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_MISAL = 2'b01;
    localparam logic [1:0] E_TMO   = 2'b10;
    localparam logic [1:0] E_ILL   = 2'b11;

    logic [1:0]      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [OW-1:0]   off_q, off_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [NB-1:0]   bus_sel_q, bus_sel_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic [1:0]      req_size;
    logic            req_illegal;
    logic            req_misal;
    logic [OW-1:0]   req_off;
    logic [NB-1:0]   req_lanes;
    logic [NB-1:0]   req_sel;
    logic [XLEN-1:0] req_wdata;
    logic [XLEN-1:0] req_addr;

    assign req_size = i_lsu_funct3[1:0];
    assign req_off  = i_lsu_addr[OW-1:0];
    assign req_addr = {i_lsu_addr[XLEN-1:OW], {OW{1'b0}}};
    assign req_sel  = req_lanes << req_off;

    always_comb begin
        req_illegal = 1'b0;
        if (i_lsu_we) begin
            req_illegal = i_lsu_funct3[2] | ((req_size == 2'b11) && (XLEN == 32));
        end else begin
            case (i_lsu_funct3)
                3'b111:         req_illegal = 1'b1;
                3'b011, 3'b110: req_illegal = (XLEN == 32);
                default:        req_illegal = 1'b0;
            endcase
        end
    end

    always_comb begin
        req_misal = 1'b0;
        req_lanes = '1;
        case (req_size)
            2'b00: begin
                req_misal = 1'b0;
                req_lanes = NB'(1);
            end
            2'b01: begin
                req_misal = i_lsu_addr[0];
                req_lanes = NB'(3);
            end
            2'b10: begin
                req_misal = |i_lsu_addr[1:0];
                req_lanes = NB'(15);
            end
            default: begin
                req_misal = |i_lsu_addr[2:0];
                req_lanes = '1;
            end
        endcase
    end

    // The store value is replicated so every lane the slave may pick holds it.
    always_comb begin
        req_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            case (req_size)
                2'b00:   req_wdata[8*i +: 8] = i_lsu_wr_data[7:0];
                2'b01:   req_wdata[8*i +: 8] = i_lsu_wr_data[8*(i%2) +: 8];
                2'b10:   req_wdata[8*i +: 8] = i_lsu_wr_data[8*(i%4) +: 8];
                default: req_wdata[8*i +: 8] = i_lsu_wr_data[8*i +: 8];
            endcase
        end
    end

    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_mask;
    logic            ld_msb;
    logic            ld_sign;
    logic [XLEN-1:0] ld_ext;

    assign ld_shift = i_bus_rd_data >> {off_q, 3'b000};

    always_comb begin
        ld_mask = '1;
        ld_msb  = ld_shift[XLEN-1];
        case (funct3_q[1:0])
            2'b00: begin
                ld_mask = XLEN'(8'hFF);
                ld_msb  = ld_shift[7];
            end
            2'b01: begin
                ld_mask = XLEN'(16'hFFFF);
                ld_msb  = ld_shift[15];
            end
            2'b10: begin
                ld_mask = XLEN'(32'hFFFF_FFFF);
                ld_msb  = ld_shift[31];
            end
            default: begin
                ld_mask = '1;
                ld_msb  = ld_shift[XLEN-1];
            end
        endcase
    end

    assign ld_sign = ~funct3_q[2] & ld_msb;
    assign ld_ext  = (ld_shift & ld_mask) | ({XLEN{ld_sign}} & ~ld_mask);

    logic to_hit;
    assign to_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        done_d      = 1'b0;
        rd_data_d   = rd_data_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (i_lsu_valid) begin
                    we_d     = i_lsu_we;
                    funct3_d = i_lsu_funct3;
                    off_d    = req_off;
                    if (req_illegal || req_misal) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        rd_data_d  = '0;
                        err_d      = 1'b1;
                        err_code_d = req_illegal ? E_ILL : E_MISAL;
                    end else begin
                        state_d     = S_BUS;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = i_lsu_we;
                        bus_addr_d  = req_addr;
                        bus_sel_d   = req_sel;
                        bus_wdata_d = req_wdata;
                    end
                end
            end
            S_BUS: begin
                if (i_bus_ack || to_hit) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_sel_d   = '0;
                    bus_wdata_d = '0;
                    // Ack takes priority over a coincident timeout.
                    if (i_bus_ack) begin
                        rd_data_d  = we_q ? '0 : ld_ext;
                        err_d      = 1'b0;
                        err_code_d = E_NONE;
                    end else begin
                        rd_data_d  = '0;
                        err_d      = 1'b1;
                        err_code_d = E_TMO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign o_lsu_ready    = (state_q == S_IDLE);
    assign o_lsu_done     = done_q;
    assign o_lsu_rd_data  = rd_data_q;
    assign o_lsu_err      = err_q;
    assign o_lsu_err_code = err_code_q;
    assign o_bus_req      = bus_req_q;
    assign o_bus_we       = bus_we_q;
    assign o_bus_addr     = bus_addr_q;
    assign o_bus_byte_sel = bus_sel_q;
    assign o_bus_wr_data  = bus_wdata_q;

endmodule
